// File: rtl/pwm_timer.sv
// PWM generator with prescaler, period counter and double-buffered config.
// Ports: clk, rst, en, load, period, duty, prescale -> pwm_out, cycle_done, running.
module pwm_timer #(
  parameter int N = 8,
  parameter int P = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] period,
  input  logic [N-1:0] duty,
  input  logic [P-1:0] prescale,
  output logic         pwm_out,
  output logic         cycle_done,
  output logic         running
);

  logic         running_q;
  logic [P-1:0] pre_cnt_q, pre_cnt_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] per_q, per_d, duty_q, duty_d;
  logic [P-1:0] pre_q, pre_d;
  logic [N-1:0] per_pq, per_pd, duty_pq, duty_pd;
  logic [P-1:0] pre_pq, pre_pd;
  logic         pv_q, pv_d;

  logic tick, wrap, fall, swap;

  assign tick = running_q && (pre_cnt_q == pre_q);
  assign wrap = tick && (cnt_q == per_q);
  assign fall = running_q && !en;
  // Period boundary or stop: the only points where config may change.
  assign swap = wrap || fall;

  always_comb begin
    pre_cnt_d = '0;
    cnt_d     = '0;
    if (en && running_q) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
      if (wrap)      cnt_d = '0;
      else if (tick) cnt_d = cnt_q + 1'b1;
      else           cnt_d = cnt_q;
    end
  end

  always_comb begin
    per_d   = per_q;
    duty_d  = duty_q;
    pre_d   = pre_q;
    per_pd  = per_pq;
    duty_pd = duty_pq;
    pre_pd  = pre_pq;
    pv_d    = pv_q;
    if (!running_q) begin
      if (load) begin
        per_d  = period;
        duty_d = duty;
        pre_d  = prescale;
      end
    end else if (load && swap) begin
      // Load coinciding with a boundary bypasses the pending stage.
      per_d  = period;
      duty_d = duty;
      pre_d  = prescale;
      pv_d   = 1'b0;
    end else if (load) begin
      per_pd  = period;
      duty_pd = duty;
      pre_pd  = prescale;
      pv_d    = 1'b1;
    end else if (swap && pv_q) begin
      per_d  = per_pq;
      duty_d = duty_pq;
      pre_d  = pre_pq;
      pv_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running_q <= 1'b0;
      pre_cnt_q <= '0;
      cnt_q     <= '0;
      per_q     <= '0;
      duty_q    <= '0;
      pre_q     <= '0;
      per_pq    <= '0;
      duty_pq   <= '0;
      pre_pq    <= '0;
      pv_q      <= 1'b0;
    end else begin
      running_q <= en;
      pre_cnt_q <= pre_cnt_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      duty_q    <= duty_d;
      pre_q     <= pre_d;
      per_pq    <= per_pd;
      duty_pq   <= duty_pd;
      pre_pq    <= pre_pd;
      pv_q      <= pv_d;
    end
  end

  assign pwm_out    = running_q && (cnt_q < duty_q);
  assign cycle_done = wrap;
  assign running    = running_q;

endmodule

// File: tb/tb_pwm_timer.sv
// Scoreboard bench for pwm_timer: clock-phase reference model vs DUT.
// Expected outputs queued per clock, checked by an independent monitor.
module tb_pwm_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] period = '0;
  logic [7:0] duty = '0;
  logic [3:0] prescale = '0;
  logic       pwm_out, cycle_done, running;

  int checks = 0;
  int errs = 0;

  pwm_timer #(.N(8), .P(4)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .period(period), .duty(duty), .prescale(prescale),
    .pwm_out(pwm_out), .cycle_done(cycle_done), .running(running)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pwm;
    logic cd;
    logic run;
  } exp_t;

  exp_t q[$];

  // Reference: t = clocks elapsed since the current period began.
  bit m_run, m_pv;
  int m_t;
  int a_per, a_duty, a_pre;
  int p_per, p_duty, p_pre;

  function automatic void m_reset();
    m_run = 0; m_pv = 0; m_t = 0;
    a_per = 0; a_duty = 0; a_pre = 0;
    p_per = 0; p_duty = 0; p_pre = 0;
  endfunction

  function automatic exp_t m_out();
    exp_t e;
    int len;
    len = a_pre + 1;
    e.run = m_run;
    e.pwm = m_run && ((m_t / len) < a_duty);
    e.cd  = m_run && ((m_t % len) == len - 1) && ((m_t / len) == a_per);
    return e;
  endfunction

  function automatic void m_step(bit e, bit l, int pr, int du, int ps);
    bit wrap, bnd;
    wrap = m_run && (m_t == (a_per + 1) * (a_pre + 1) - 1);
    bnd = wrap || (m_run && !e);
    if (!m_run || !e || wrap) m_t = 0;
    else m_t = m_t + 1;
    if (!m_run) begin
      if (l) begin a_per = pr; a_duty = du; a_pre = ps; end
    end else if (l && bnd) begin
      a_per = pr; a_duty = du; a_pre = ps; m_pv = 0;
    end else if (l) begin
      p_per = pr; p_duty = du; p_pre = ps; m_pv = 1;
    end else if (bnd && m_pv) begin
      a_per = p_per; a_duty = p_duty; a_pre = p_pre; m_pv = 0;
    end
    m_run = e;
  endfunction

  task automatic cyc(input bit e, input bit l, input int pr,
                     input int du, input int ps);
    en = e; load = l;
    period = 8'(pr); duty = 8'(du); prescale = 4'(ps);
    @(posedge clk);
    m_step(e, l, pr, du, ps);
    q.push_back(m_out());
    #1;
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
  endtask

  task automatic chk(input string nm, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("running", running, e.run);
      chk("pwm_out", pwm_out, e.pwm);
      chk("cycle_done", cycle_done, e.cd);
    end
  end

  initial begin
    #1_000_000;
    errs++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errs);
    $finish;
  end

  initial begin
    m_reset();
    #1;
    chk("rst_pwm", pwm_out, 1'b0);
    chk("rst_cd", cycle_done, 1'b0);
    chk("rst_run", running, 1'b0);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;

    // basic 5-clock waveform
    cyc(0, 1, 4, 2, 0);
    run(15);
    // prescaled
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 2);
    run(15);
    // edge duties
    cyc(0, 1, 4, 0, 0); run(8);
    cyc(0, 1, 4, 9, 0); run(8);
    cyc(0, 1, 0, 1, 0); run(6);
    // mid-run loads at every offset, incl. the wrap clock
    for (int off = 0; off < 7; off++) begin
      cyc(0, 1, 4, 2, 0);
      run(off);
      cyc(1, 1, 9, 5, 0);
      run(2);
      cyc(1, 1, 3, 1, 0);
      run(14);
    end
    // en drop with a pending load, then restart
    cyc(0, 1, 4, 2, 0);
    run(3);
    cyc(1, 1, 6, 3, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    run(16);

    // async reset between edges
    run(3);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("arst_pwm", pwm_out, 1'b0);
    chk("arst_cd", cycle_done, 1'b0);
    chk("arst_run", running, 1'b0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    m_reset();
    run(6);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit e, l;
      e = ($urandom_range(0, 19) != 0);
      l = ($urandom_range(0, 9) == 0);
      cyc(e, l, $urandom_range(0, 10), $urandom_range(0, 12),
          $urandom_range(0, 3));
    end

    @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d left expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errs);
    $finish;
  end

endmodule
